// File: rtl/rgb_colour_decoder.sv
// ============================================================================
// Module   : rgb_colour_decoder
// Purpose  : Thresholds a streamed 24-bit RGB pixel back to a 3-bit palette
//            code, behind a valid/ready handshake and a 2-entry result buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rgb_colour_decoder #(
    parameter logic [7:0] THRESH = 8'h80,
    parameter int         CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [23:0]      rgb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       color,
    output logic             exact,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       occ_q, occ_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic [1:0][3:0]  mem_q, mem_d;
    logic [2:0]       color_q, color_d;
    logic             exact_q, exact_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       accept;
    logic       deliver;
    logic [2:0] pix_color;
    logic       pix_exact;
    logic [3:0] head;

    function automatic logic byte_exact(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF);
    endfunction

    assign pix_color = {rgb[23:16] >= THRESH, rgb[15:8] >= THRESH, rgb[7:0] >= THRESH};
    assign pix_exact = byte_exact(rgb[23:16]) && byte_exact(rgb[15:8]) && byte_exact(rgb[7:0]);

    // Ready looks only at stored occupancy, never at out_ready.
    assign in_ready  = rst_n && enable && (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        if (accept) begin
            mem_d[wr_ptr_q] = {pix_color, pix_exact};
            wr_ptr_d        = ~wr_ptr_q;
            if (!pix_exact && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
        if (deliver) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({accept, deliver})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
        // Outputs are a registered copy of the next head; they hold when empty.
        head    = mem_d[rd_ptr_d];
        color_d = color_q;
        exact_d = exact_q;
        if (occ_d != 2'd0) begin
            color_d = head[3:1];
            exact_d = head[0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            mem_q    <= '0;
            color_q  <= 3'b000;
            exact_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            occ_q    <= occ_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            mem_q    <= mem_d;
            color_q  <= color_d;
            exact_q  <= exact_d;
            cnt_q    <= cnt_d;
        end
    end

    assign color        = color_q;
    assign exact        = exact_q;
    assign mismatch_cnt = cnt_q;

endmodule

`default_nettype wire

// File: doc/rgb_colour_decoder.md
Name: rgb_colour_decoder

Overview:
- Inverse of the team's RGB colour converter: turns a streamed 24-bit RGB pixel back into a 3-bit palette colour code.
- Each channel is compared against a threshold.
- Flags whether the pixel was an exact palette colour and counts pixels that were not.
- Sits downstream of the converter (or any 24-bit pixel source), behind a valid/ready handshake with a 2-entry output buffer.

Parameters:
- THRESH, 8'h80: per-channel threshold; a channel byte >= THRESH decodes to 1.
- CNT_W, 8: width of the saturating non-palette pixel counter.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- enable, input, 1: when 0, no new pixels are accepted; buffered results still drain.
- in_valid, input, 1: rgb holds a valid pixel.
- in_ready, output, 1: block can accept a pixel this cycle.
- rgb, input, 24: pixel; [23:16] = colour bit 2 channel, [15:8] = bit 1, [7:0] = bit 0.
- out_valid, output, 1: color/exact hold a valid result.
- out_ready, input, 1: consumer takes the result this cycle.
- color, output, 3: decoded palette code.
- exact, output, 1: 1 if every channel byte was 8'h00 or 8'hFF.
- mismatch_cnt, output, CNT_W: number of accepted pixels with exact=0; saturating.

Behaviour:
- Reset (rst_n=0, async):
  - Buffer emptied.
  - out_valid=0, color=3'b000, exact=0, mismatch_cnt=0.
  - in_ready=0 while rst_n=0.
- Accept: a pixel is taken on a rising edge when in_valid && in_ready.
- Ready: in_ready = enable && (buffer occupancy < 2). Combinational from registered occupancy and enable only; it does not depend on out_ready.
- Deliver: a result leaves on a rising edge when out_valid && out_ready.
- Decode, per pixel at acceptance:
  - color[2] = (rgb[23:16] >= THRESH)
  - color[1] = (rgb[15:8] >= THRESH)
  - color[0] = (rgb[7:0] >= THRESH)
  - exact = AND over channels of (byte==8'h00 || byte==8'hFF).
  - Comparisons are unsigned, 8-bit.
- Buffer: 2-entry FIFO of {color, exact}; head drives the color/exact outputs.
- Latency:
  - Pixel accepted at edge N into an empty buffer -> out_valid=1 with its result after edge N (visible in cycle N+1).
  - Results leave in order.
- out_valid = (occupancy != 0).
- When out_valid=0, color/exact hold their last value (3'b000/0 after reset); the consumer ignores them.
- Simultaneous accept and deliver at occupancy 1: occupancy stays 1; the new result becomes the head next cycle.
- Occupancy 2: in_ready=0. A deliver that edge drops occupancy to 1, so in_ready=1 the following cycle (one bubble is accepted).
- Stall: out_ready=0 holds the head stable; out_valid stays 1.
- mismatch_cnt:
  - Increments by 1 on each accepted pixel with exact=0.
  - Holds at all-ones (255 for CNT_W=8).
  - Not affected by enable or out_ready.
- enable deasserted mid-stream: no accept that cycle; buffered entries continue to drain normally.
- Reset mid-operation: buffer contents are discarded immediately (out_valid drops asynchronously); no partial result is delivered after release.
- in_valid with in_ready=0: no accept, no state change; the source holds the pixel.

Test Plan:
- Palette sweep: rst_n 0->1, enable=1, out_ready=1; drive rgb for each code 0..7 (e.g. 24'hFF00FF) with in_valid=1 -> color matches the code (24'hFF00FF -> 3'b101), exact=1, one cycle after each accept; mismatch_cnt=0.
- Threshold boundary:
  - rgb=24'h80_7F_00 -> color=3'b100, exact=0, mismatch_cnt=1.
  - rgb=24'h7F_80_FF -> color=3'b011, exact=0, mismatch_cnt=2.
- Backpressure: out_ready=0, push 3 pixels back-to-back -> first two accepted; in_ready=0 from the cycle after the second accept. Raise out_ready -> results emerge in order; the third pixel is accepted after the first pop.
- Enable gating: enable=0 with in_valid=1 for 3 cycles -> in_ready=0, no accept, mismatch_cnt unchanged; previously buffered result still delivered.
- Counter saturation: 260 accepted pixels of rgb=24'h101010 -> mismatch_cnt=255 and stays 255; every result has color=3'b000, exact=0.
- Async reset mid-stream: buffer holding 2 entries, pulse rst_n low between edges -> out_valid=0 and mismatch_cnt=0 immediately. After release, the first result seen is from the first post-reset accept.
